// File: rtl/debounce_pkg.sv
// Purpose: shared defaults, the per-channel pulse bundle and the counter-width helper for the debounce bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debounce_pkg;

    localparam int unsigned DEF_N_CH          = 4;
    localparam int unsigned DEF_STABLE_CYCLES = 50000;
    localparam int unsigned DEF_LONG_CYCLES   = 25000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 0;
    localparam bit          DEF_ACTIVE_LOW    = 1'b0;

    // One channel's event pulses, all one cycle wide.
    typedef struct packed {
        logic up;
        logic dn;
        logic long_press;
        logic rpt;
    } ch_pulse_t;

    // Bits needed to hold values 0..max_count; never narrower than 1.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Purpose: switch inputs and debounced state/event outputs of the debounce bank.
// Latency: n/a (wires only).
// Backpressure: none; events are fire-and-forget pulses.
// master = the side driving switches and consuming events; slave = the debounce bank.
interface debounce_bank_if
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH
) ();

    logic [N_CH-1:0] switch_in;   // raw asynchronous switch levels
    logic [N_CH-1:0] state;       // debounced level, 1 = pressed
    logic [N_CH-1:0] trans_up;    // pulse on debounced 0->1
    logic [N_CH-1:0] trans_dn;    // pulse on debounced 1->0
    logic [N_CH-1:0] long_press;  // pulse once a press has been held long enough
    logic [N_CH-1:0] rpt;         // auto-repeat pulse while held after a long press
    logic            any_event;   // OR of all pulses across all channels

    modport master (
        output switch_in,
        input  state, trans_up, trans_dn, long_press, rpt, any_event
    );

    modport slave (
        input  switch_in,
        output state, trans_up, trans_dn, long_press, rpt, any_event
    );

endinterface

// File: rtl/debounce_channel.sv
// Purpose: one switch channel: 2-flop sync, stability counter, hold counter, event pulses.
// Latency: state and up/dn pulse appear STABLE_CYCLES+2 edges after raw first sampled at a new level.
// Backpressure: none; pulses are one cycle and never held.
// Ports: clk, rst (async high), raw (already polarity-corrected), state, pulse (registered),
//        pulse_nxt (value pulse takes on the next edge, for registered cross-channel OR).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      raw,
    output logic      state,
    output ch_pulse_t pulse,
    output ch_pulse_t pulse_nxt
);

    localparam int unsigned SW = cnt_width(STABLE_CYCLES);
    localparam int unsigned HW = cnt_width(max2(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam bit            REPEAT_EN   = (REPEAT_CYCLES != 0);

    logic          sync1, sync2;
    logic [SW-1:0] stab_cnt, stab_cnt_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic          long_done, long_done_nxt;
    logic          state_nxt;
    logic          toggle;

    always_comb begin
        toggle        = (sync2 != state) && (stab_cnt == STABLE_LAST);
        state_nxt     = state ^ toggle;
        stab_cnt_nxt  = '0;
        hold_cnt_nxt  = hold_cnt;
        long_done_nxt = long_done;
        pulse_nxt     = '0;

        if ((sync2 != state) && !toggle) begin
            stab_cnt_nxt = stab_cnt + 1'b1;
        end

        pulse_nxt.up = toggle & ~state;
        pulse_nxt.dn = toggle & state;

        // Hold timing restarts from zero at each long/repeat pulse so the
        // counter never has to wrap. A release on the due edge wins over
        // the long/repeat pulse.
        if (!state) begin
            hold_cnt_nxt  = '0;
            long_done_nxt = 1'b0;
        end else if (!long_done) begin
            if (hold_cnt == LONG_LAST) begin
                hold_cnt_nxt         = '0;
                long_done_nxt        = 1'b1;
                pulse_nxt.long_press = ~toggle;
            end else begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end else if (REPEAT_EN) begin
            if (hold_cnt == REPEAT_LAST) begin
                hold_cnt_nxt  = '0;
                pulse_nxt.rpt = ~toggle;
            end else begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end
        // With repeat disabled the counter parks after the long press.
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stab_cnt  <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            state     <= 1'b0;
            pulse     <= '0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            stab_cnt  <= stab_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            long_done <= long_done_nxt;
            state     <= state_nxt;
            pulse     <= pulse_nxt;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Purpose: N_CH independent switch debouncers with press/release/long/repeat events and a global event flag.
// Latency: events STABLE_CYCLES+2 edges after a raw level change; any_event in the same cycle as the pulses.
// Backpressure: none; all outputs are free-running pulses/levels.
// Ports: clk, rst (async high), bus (slave side of debounce_bank_if).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
    input  logic           clk,
    input  logic           rst,
    debounce_bank_if.slave bus
);

    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] evt_nxt;
    ch_pulse_t       pulse     [N_CH];
    ch_pulse_t       pulse_nxt [N_CH];

    // Inversion happens before the synchroniser so reset's 0 means "released".
    assign lvl = ACTIVE_LOW ? ~bus.switch_in : bus.switch_in;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .raw       (lvl[g]),
            .state     (bus.state[g]),
            .pulse     (pulse[g]),
            .pulse_nxt (pulse_nxt[g])
        );

        assign bus.trans_up[g]   = pulse[g].up;
        assign bus.trans_dn[g]   = pulse[g].dn;
        assign bus.long_press[g] = pulse[g].long_press;
        assign bus.rpt[g]        = pulse[g].rpt;
        assign evt_nxt[g]        = |pulse_nxt[g];
    end

    // Registered from next-cycle pulse values so it lines up with the pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.any_event <= 1'b0;
        end else begin
            bus.any_event <= |evt_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    debounce_bank_if #(.N_CH(3)) ifa ();
    debounce_bank_if #(.N_CH(3)) ifb ();

    debounce_bank #(
        .N_CH(3), .STABLE_CYCLES(4), .LONG_CYCLES(16), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    debounce_bank #(
        .N_CH(3), .STABLE_CYCLES(4), .LONG_CYCLES(16), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    // {any_event, rpt, long_press, trans_dn, trans_up, state}
    logic [15:0] obs_a, obs_b;
    assign obs_a = {ifa.any_event, ifa.rpt, ifa.long_press, ifa.trans_dn, ifa.trans_up, ifa.state};
    assign obs_b = {ifb.any_event, ifb.rpt, ifb.long_press, ifb.trans_dn, ifb.trans_up, ifb.state};

    function automatic logic [15:0] pack(input logic [2:0] st, input logic [2:0] up,
                                         input logic [2:0] dn, input logic [2:0] lp,
                                         input logic [2:0] rp);
        return {|{up, dn, lp, rp}, rp, lp, dn, up, st};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves rst released just after an edge, so the next edge is edge 1.
    task automatic reset_a();
        rst = 1'b1;
        ifa.switch_in = 3'b000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Input already high from edge 1: state/trans_up for mask m expected at edge 6.
    task automatic check_rise(input string nm, input logic [2:0] m);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("%s_k%0d", nm, k), obs_a,
                pack((k >= 6) ? m : 3'b000, (k == 6) ? m : 3'b000, 3'b000, 3'b000, 3'b000));
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        ifa.switch_in = 3'b000;
        ifb.switch_in = 3'b000;   // active-low: all pressed
        tick();
        tick();
        tick();
        chk("reset_a", obs_a, 16'h0000);
        chk("reset_b_pressed", obs_b, 16'h0000);

        // Active-low bank pressed through reset; A idle.
        rst = 1'b0;
        rst_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("alow_k%0d", k), obs_b,
                pack((k >= 6) ? 3'b111 : 3'b000, (k == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000, 3'b000));
            chk($sformatf("idle_k%0d", k), obs_a, 16'h0000);
        end

        // ch0 long hold: up@6, long@22, repeat@30,38; release sampled @41 -> dn@46,
        // where the repeat due at 46 must be suppressed.
        reset_a();
        ifa.switch_in = 3'b001;
        for (int k = 1; k <= 50; k++) begin
            if (k == 41) ifa.switch_in = 3'b000;
            tick();
            chk($sformatf("hold_k%0d", k), obs_a,
                pack({2'b00, (k >= 6 && k < 46)}, {2'b00, k == 6}, {2'b00, k == 46},
                     {2'b00, k == 22}, {2'b00, (k == 30 || k == 38)}));
        end

        // ch1 glitch train: 3 high / 1 low, never stable long enough.
        reset_a();
        for (int k = 1; k <= 24; k++) begin
            ifa.switch_in = {1'b0, (k <= 16) && (((k - 1) % 4) < 3), 1'b0};
            tick();
            chk($sformatf("glitch_k%0d", k), obs_a, 16'h0000);
        end

        // ch0 and ch2 together.
        reset_a();
        ifa.switch_in = 3'b101;
        check_rise("dual", 3'b101);

        // ch1 short press: 10 cycles, release sampled @11 -> dn@16, no long press.
        reset_a();
        for (int k = 1; k <= 30; k++) begin
            ifa.switch_in = (k <= 10) ? 3'b010 : 3'b000;
            tick();
            chk($sformatf("short_k%0d", k), obs_a,
                pack({1'b0, (k >= 6 && k < 16), 1'b0}, {1'b0, k == 6, 1'b0},
                     {1'b0, k == 16, 1'b0}, 3'b000, 3'b000));
        end

        // Reset while trans_up is high clears outputs without a clock edge.
        reset_a();
        ifa.switch_in = 3'b001;
        check_rise("pre_rst", 3'b001);
        for (int k = 1; k <= 6; k++) tick();
        reset_a();
        ifa.switch_in = 3'b001;
        for (int k = 1; k <= 6; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", obs_a, 16'h0000);
        tick();
        rst = 1'b0;
        check_rise("after_rst", 3'b001);

        // Reset two cycles into the stability count discards progress.
        reset_a();
        ifa.switch_in = 3'b001;
        for (int k = 1; k <= 4; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midcount_rst", obs_a, 16'h0000);
        tick();
        rst = 1'b0;
        check_rise("midcount_after", 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent switch channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 50000: consecutive stable cycles needed to accept a new level (>=1).
REQ-003 Parameter LONG_CYCLES, default 25000000: cycles of accepted press before the long_press pulse (>=1).
REQ-004 Parameter REPEAT_CYCLES, default 0: auto-repeat period after long press; 0 disables repeat.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 means a raw input low = pressed; the input is inverted before synchronisation.
REQ-006 CLK  input  1  sole clock; all state on rising edge.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 switch_in  input  N_CH  raw asynchronous switch levels.
REQ-009 state  output  N_CH  debounced level per channel, 1 = pressed.
REQ-010 trans_up  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-011 trans_dn  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-012 long_press  output  N_CH  one-cycle pulse when press held LONG_CYCLES.
REQ-013 repeat  output  N_CH  one-cycle auto-repeat pulse.
REQ-014 any_event  output  1  registered OR of trans_up|trans_dn|long_press|repeat across channels, same cycle as those pulses.

Function
REQ-015 Each channel passes through a 2-flop synchroniser; channels are fully independent.
REQ-016 Stability counter, width $clog2(STABLE_CYCLES+1): increments each cycle synchronised level != state; clears whenever equal.
REQ-017 When counter == STABLE_CYCLES-1 and level still differs, state toggles and counter clears; latency: state changes on rising edge STABLE_CYCLES+2 after the input is first sampled at its new level.
REQ-018 Any glitch shorter than STABLE_CYCLES synchronised cycles produces no state change and no pulses.
REQ-019 trans_up/trans_dn are registered and assert exactly in the cycle the new state value is first visible.
REQ-020 Hold counter, width $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1): clears while state==0; counts while state==1.
REQ-021 long_press pulses once, LONG_CYCLES cycles after trans_up; never repeats within one press.
REQ-022 With REPEAT_CYCLES>0, repeat pulses every REPEAT_CYCLES cycles after long_press until release; hold counter reloads, never wraps.
REQ-023 Release (trans_dn) in the same cycle a long/repeat pulse would be due suppresses that pulse.
REQ-024 Simultaneous events on several channels are all reported in the same cycle; no arbitration.

Reset
REQ-025 RST asserted: synchronisers load inactive level (0 after polarity inversion), all counters 0, state 0, all pulse outputs and any_event 0.
REQ-026 RST asserted mid-count or mid-press discards progress; no pulses emitted on or after release of RST unless input then meets REQ-017.
REQ-027 Input already pressed at reset release yields trans_up STABLE_CYCLES+2 cycles later.

Structure
REQ-028 Shared package debounce_pkg holds default parameter constants and the counter-width helper function.
REQ-029 One sub-module debounce_channel (one channel: sync, stability counter, hold counter, pulses), instantiated N_CH times via generate; top adds polarity inversion and any_event.

Verification (N_CH=3, STABLE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8, ACTIVE_LOW=0)
REQ-030 ch0 0->1 held 30 cycles -> trans_up[0] on edge 6, state[0]=1, long_press[0] 16 cycles later, repeat[0] 8 cycles after that.
REQ-031 ch1 high-pulses of 3 cycles each, separated by 1 low cycle -> state[1] stays 0, no pulses, any_event 0.
REQ-032 ch0 and ch2 rise same cycle -> trans_up=3'b101 in one cycle, any_event single pulse.
REQ-033 Press ch1 then release after 10 cycles -> trans_up, then trans_dn 6 cycles after release, no long_press.
REQ-034 RST asserted 2 cycles into a stable press count -> all outputs 0 asynchronously; after release, trans_up 6 cycles later.
REQ-035 ACTIVE_LOW=1, input held low from reset -> trans_up at edge 6 after reset release, state=1.
